irq_ctrl: RTL

- Interrupt controller sitting directly upstream of the CPU control unit.
- Synchronises and edge-detects external interrupt lines, then latches them as pending and prioritises them.
- Raises O_irq_active toward the control unit and serves the one-cycle I_irq_ack handshake by presenting a 16-bit ISR vector.
- Blocks further requests until the ISR signals end-of-interrupt.

---
 rtl/irq_ctrl_pkg.sv | 26 ++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/irq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared types, widths and vector helper for the interrupt controller
package irq_ctrl_pkg;

    // Width of a line index; covers up to 16 interrupt lines.
    localparam int IRQ_IDX_W = 4;
    // Width of the ISR vector presented to the control unit.
    localparam int IRQ_VEC_W = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } irq_state_e;

    // Vector for a given line index. The spurious vector is the slot one past the
    // last real line, i.e. idx = NUM_IRQ. Arithmetic wraps at 16 bits.
    function automatic logic [IRQ_VEC_W-1:0] irq_vector(
        input logic [IRQ_VEC_W-1:0] base,
        input int                   stride,
        input int                   idx
    );
        logic [31:0] offset;
        offset = 32'(idx * stride);
        return base + offset[IRQ_VEC_W-1:0];
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest requesting index wins
//
// Ports:
//   req   in  NUM_IRQ  requesting lines (pending & enable)
//   valid out 1        at least one line is requesting
//   idx   out 4        index of the lowest requesting line (0 when none)
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]   req,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    // Scan from the top down so the last hit, the lowest index, is what remains.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-triggered, prioritised interrupt controller with ack/EOI handshake
//
// Ports:
//   I_clk          in  1        system clock, rising edge
//   I_reset        in  1        synchronous active-high reset
//   I_irq_lines    in  NUM_IRQ  asynchronous rising-edge interrupt requests
//   I_irq_en_we    in  1        enable register write strobe
//   I_irq_en       in  NUM_IRQ  new enable mask (1 = enabled)
//   I_irq_ack      in  1        acknowledge pulse from the control unit
//   I_irq_eoi      in  1        end-of-interrupt pulse from return-from-ISR
//   O_irq_active   out 1        interrupt request to the control unit
//   O_irq_vector   out 16       vector of the last acknowledged interrupt
//   O_irq_spurious out 1        last ack found nothing to serve
//   O_pending      out NUM_IRQ  raw pending bits
//   O_in_service   out 1        an ISR is running
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                   NUM_IRQ       = 8,
    parameter logic [IRQ_VEC_W-1:0] VECTOR_BASE   = 16'h0010,
    parameter int                   VECTOR_STRIDE = 2
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic [NUM_IRQ-1:0]   I_irq_lines,
    input  logic                 I_irq_en_we,
    input  logic [NUM_IRQ-1:0]   I_irq_en,
    input  logic                 I_irq_ack,
    input  logic                 I_irq_eoi,
    output logic                 O_irq_active,
    output logic [IRQ_VEC_W-1:0] O_irq_vector,
    output logic                 O_irq_spurious,
    output logic [NUM_IRQ-1:0]   O_pending,
    output logic                 O_in_service
);

    localparam logic [IRQ_VEC_W-1:0] SPURIOUS_VECTOR =
        irq_vector(VECTOR_BASE, VECTOR_STRIDE, NUM_IRQ);

    // Synchroniser and edge-detect pipeline.
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;
    logic [NUM_IRQ-1:0] sync3_q, sync3_d;

    // After reset the sync flops hold zeros rather than real samples, so a line
    // that is already high would look like a fresh rising edge. prime_q counts
    // the cycles until sync2 carries real data; a line is armed only once it
    // has been genuinely seen low, so a held line must fall and rise again.
    logic [1:0]         prime_q, prime_d;
    logic               primed;
    logic [NUM_IRQ-1:0] armed_q, armed_d;

    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   en_q, en_d;
    irq_state_e           state_q, state_d;
    logic                 active_q, active_d;
    logic [IRQ_VEC_W-1:0] vector_q, vector_d;
    logic                 spurious_q, spurious_d;

    logic [NUM_IRQ-1:0]   edge_det;
    logic [NUM_IRQ-1:0]   clear;
    logic                 win_valid;
    logic [IRQ_IDX_W-1:0] win_idx;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req   (pending_q & en_q),
        .valid (win_valid),
        .idx   (win_idx)
    );

    assign primed = (prime_q == 2'd2);

    always_comb begin
        sync1_d = I_irq_lines;
        sync2_d = sync1_q;
        sync3_d = sync2_q;

        prime_d  = primed ? prime_q : prime_q + 2'd1;
        armed_d  = armed_q | ({NUM_IRQ{primed}} & ~sync2_q);
        edge_det = sync2_q & ~sync3_q & armed_q;

        en_d = I_irq_en_we ? I_irq_en : en_q;

        clear      = '0;
        state_d    = state_q;
        vector_d   = vector_q;
        spurious_d = spurious_q;

        case (state_q)
            ST_IDLE: begin
                // EOI is meaningless here and is dropped.
                if (I_irq_ack) begin
                    if (win_valid) begin
                        vector_d   = irq_vector(VECTOR_BASE, VECTOR_STRIDE, int'(win_idx));
                        spurious_d = 1'b0;
                        state_d    = ST_SERVICE;
                        for (int i = 0; i < NUM_IRQ; i++) begin
                            clear[i] = (win_idx == IRQ_IDX_W'(i));
                        end
                    end else begin
                        vector_d   = SPURIOUS_VECTOR;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_SERVICE: begin
                // EOI has precedence; any ack seen here is ignored.
                if (I_irq_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge on the bit being cleared re-sets it, so it is not lost.
        pending_d = (pending_q & ~clear) | edge_det;

        // Request drops in the cycle after an ack is taken and stays low
        // throughout SERVICE.
        active_d = (state_d == ST_IDLE) && win_valid;
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            prime_q    <= '0;
            armed_q    <= '0;
            pending_q  <= '0;
            en_q       <= '0;
            state_q    <= ST_IDLE;
            active_q   <= 1'b0;
            vector_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            prime_q    <= prime_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            en_q       <= en_d;
            state_q    <= state_d;
            active_q   <= active_d;
            vector_q   <= vector_d;
            spurious_q <= spurious_d;
        end
    end

    assign O_irq_active   = active_q;
    assign O_irq_vector   = vector_q;
    assign O_irq_spurious = spurious_q;
    assign O_pending      = pending_q;
    assign O_in_service   = (state_q == ST_SERVICE);

endmodule
